control_pipeline: RTL and testbench
===================================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 Parameters SHALL be: ALUCTRL_W = 4 (ALU operation code width); REG_W = 5 (register-index width); FORWARD_EN = 1 (1 = operand forwarding, 0 = stall-only hazard resolution).
REQ-002 Ports, in order:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- op  in  7  D-stage opcode.
- funct3  in  3  D-stage funct3.
- funct7  in  7  D-stage funct7.
- rs1D, rs2D, rdD  in  REG_W  D-stage register indices.
- ZeroE, LtE, LtuE  in  1  EX-stage flags from rs1-rs2: equal, signed less-than, unsigned less-than.
- StallF, StallD, FlushD  out  1  fetch hold, decode hold, decode bubble.
- PCSrcE  out  2  00 = PC+4, 01 = PC+imm, 11 = rs1+imm.
- ALUControlE  out  ALUCTRL_W  EX ALU operation.
- ALUSrcE  out  1  1 = immediate operand.
- ImmSrcD  out  3  D-stage immediate format.
- ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result.
- MemWriteM  out  1  data-memory write.
- MemSrcM  out  3  access size/sign; equals funct3.
- RegWriteW  out  1  register write.
- ResultSrcW  out  1  1 = memory data.
- RWSrcW  out  1  1 = PC+4 writeback.
- rdE, rdM, rdW  out  REG_W  destination index per stage.

Function
REQ-003 D stage SHALL decode combinationally the RV32I classes R, I-ALU, load, store, branch, JAL, JALR, LUI, AUIPC; any other opcode SHALL decode as an all-zero NOP bundle.
REQ-004 ALUControl SHALL cover ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU and PASSB (LUI); funct7[5] SHALL select SUB/SRA for R-type and SRA for I-type shifts.
REQ-005 Pipeline registers D->E, E->M and M->W SHALL hold the control bundle and rd; each stage advance costs exactly one cycle.
REQ-006 D->E SHALL load a zero bundle when FlushE (internal) = 1; E->M and M->W SHALL never stall.
REQ-007 Branch resolution in E: BEQ Zero, BNE !Zero, BLT Lt, BGE !Lt, BLTU Ltu, BGEU !Ltu -> PCSrcE = 01; JAL -> 01; JALR -> 11; otherwise 00.
REQ-008 PCSrcE != 00 SHALL assert FlushD and FlushE in the same cycle.
REQ-009 Load-use: if E is a load and rdE != 0 and rdE equals rs1D or rs2D, then StallF = StallD = FlushE = 1 for exactly one cycle.
REQ-010 FORWARD_EN = 1: ForwardAE = 10 if RegWriteM and rdM != 0 and rdM == rs1E; else 01 if RegWriteW and rdW != 0 and rdW == rs1E; else 00. ForwardBE uses the same rule on rs2E. M SHALL take priority.
REQ-011 FORWARD_EN = 0: Forward outputs SHALL be held at 00. Stall-and-bubble SHALL apply while rs1D or rs2D (nonzero) matches a writing rdE or rdM. The register file writes first-half, so W needs no stall.
REQ-012 If a redirect (REQ-008) and a stall (REQ-009/011) occur together, the redirect SHALL win: flush asserted, no stall.
REQ-013 Register index 0 SHALL never trigger a hazard or a forward.

Reset
REQ-014 While rst_n = 0, all pipeline registers SHALL clear to the NOP bundle. All registered outputs SHALL then read 0, and Stall/Flush/Forward SHALL read 0.
REQ-015 Reset asserted mid-stall or mid-flush SHALL abort that stall or flush immediately. The first instruction after release SHALL decode normally.

Structure
REQ-016 A shared package ctrl_pkg SHALL hold the opcode constants, the alu_op_t, imm_src_t and pcsrc_t enums, and a packed ctrl_bundle_t struct.
REQ-017 A combinational sub-module main_decoder SHALL implement REQ-003/004. control_pipeline SHALL own the registers, hazard logic and forwarding logic.

Verification
REQ-018 Reset: assert rst_n = 0 with random op inputs -> all outputs 0; after release, ADDI at D -> ALUSrcE = 1 and ALUControlE = ADD one cycle later.
REQ-019 Load-use: LW x5, then ADD x6,x5,x1 -> one stall cycle with one bubble; the ADD reaches E with ForwardAE = 01.
REQ-020 Back-to-back ALU: ADD x3; SUB x4,x3,x3 -> ForwardAE = ForwardBE = 10, zero stalls. With FORWARD_EN = 0 -> two stall cycles.
REQ-021 BLT with LtE = 1 -> PCSrcE = 01 with FlushD = 1; next cycle E holds a NOP. BGEU with LtuE = 1 -> PCSrcE = 00.
REQ-022 JALR in E concurrent with a load-use in D -> PCSrcE = 11, FlushD = 1, StallF = 0. The JALR reaches W with RWSrcW = 1 and RegWriteW = 1.
REQ-023 Writes to x0 (LW x0 then use x0) -> no stall, Forward = 00.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, decode enums
// and the control bundle that travels down the pipeline registers.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_RS1   = 2'b11
    } pcsrc_t;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;  // 1 = load data
        logic       rw_src;      // 1 = PC+4 (link)
        logic       mem_write;
        logic       alu_src;
        alu_op_t    alu_op;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t NOP_BUNDLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Combinational RV32I main decoder: opcode/funct fields to a control bundle
// plus the D-stage immediate format. Unknown opcodes yield the NOP bundle.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t ctrl,
    output imm_src_t     imm_src
);

    alu_op_t arith_op;
    logic    unused_funct7;

    // Only bit 5 of funct7 distinguishes SUB/SRA in the supported subset.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        case (funct3)
            3'b000:  arith_op = (op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        ctrl    = NOP_BUNDLE;
        imm_src = IMM_I;
        case (op)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = arith_op;
                ctrl.funct3    = funct3;
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = arith_op;
                ctrl.funct3    = funct3;
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.funct3     = funct3;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.funct3    = funct3;
                imm_src        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                ctrl.funct3 = funct3;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.rw_src    = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.funct3    = funct3;
                imm_src        = IMM_J;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.rw_src    = 1'b1;
                ctrl.jalr      = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.funct3    = funct3;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_PASSB;
                ctrl.funct3    = funct3;
                imm_src        = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.funct3    = funct3;
                imm_src        = IMM_U;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// Five-stage pipeline control: D->E->M->W control registers, branch
// resolution in E, load-use / RAW hazard stalls and operand forwarding.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 4,
    parameter int REG_W      = 5,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [REG_W-1:0]     rs1D,
    input  logic [REG_W-1:0]     rs2D,
    input  logic [REG_W-1:0]     rdD,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic [1:0]           PCSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic [2:0]           ImmSrcD,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MemWriteM,
    output logic [2:0]           MemSrcM,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic                 RWSrcW,
    output logic [REG_W-1:0]     rdE,
    output logic [REG_W-1:0]     rdM,
    output logic [REG_W-1:0]     rdW
);

    ctrl_bundle_t     ctrl_d, ctrl_e, ctrl_m, ctrl_w;
    imm_src_t         imm_src_d;
    logic [REG_W-1:0] rs1E, rs2E;
    pcsrc_t           pcsrc_e;
    logic             take_e, redirect, hazard, stall, flush_e;
    logic             unused_w;

    main_decoder u_main_decoder (
        .op      (op),
        .funct3  (funct3),
        .funct7  (funct7),
        .ctrl    (ctrl_d),
        .imm_src (imm_src_d)
    );

    function automatic logic hit(input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] a,
                                 input logic [REG_W-1:0] b);
        return (rd != '0) && ((rd == a) || (rd == b));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                           input logic             wr_m,
                                           input logic [REG_W-1:0] rd_m,
                                           input logic             wr_w,
                                           input logic [REG_W-1:0] rd_w);
        if (!FORWARD_EN)                          return 2'b00;
        if (wr_m && rd_m != '0 && rd_m == rs)     return 2'b10;
        if (wr_w && rd_w != '0 && rd_w == rs)     return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        case (ctrl_e.funct3)
            3'b000:  take_e = ZeroE;
            3'b001:  take_e = !ZeroE;
            3'b100:  take_e = LtE;
            3'b101:  take_e = !LtE;
            3'b110:  take_e = LtuE;
            3'b111:  take_e = !LtuE;
            default: take_e = 1'b0;
        endcase
        pcsrc_e = PC_PLUS4;
        if (ctrl_e.jalr)
            pcsrc_e = PC_RS1;
        else if (ctrl_e.jump || (ctrl_e.branch && take_e))
            pcsrc_e = PC_IMM;
    end

    // Stall-only mode must also wait out the M stage; the first-half regfile write covers W.
    always_comb begin
        if (FORWARD_EN)
            hazard = ctrl_e.reg_write && ctrl_e.result_src && hit(rdE, rs1D, rs2D);
        else
            hazard = (ctrl_e.reg_write && hit(rdE, rs1D, rs2D)) ||
                     (ctrl_m.reg_write && hit(rdM, rs1D, rs2D));
    end

    // A redirect discards the stalled D instruction anyway, so it overrides the stall.
    assign redirect = (pcsrc_e != PC_PLUS4);
    assign stall    = hazard && !redirect;
    assign flush_e  = redirect || stall;

    assign StallF      = stall;
    assign StallD      = stall;
    assign FlushD      = redirect;
    assign PCSrcE      = pcsrc_e;
    assign ImmSrcD     = imm_src_d;
    assign ALUControlE = ALUCTRL_W'(ctrl_e.alu_op);
    assign ALUSrcE     = ctrl_e.alu_src;
    assign MemWriteM   = ctrl_m.mem_write;
    assign MemSrcM     = ctrl_m.funct3;
    assign RegWriteW   = ctrl_w.reg_write;
    assign ResultSrcW  = ctrl_w.result_src;
    assign RWSrcW      = ctrl_w.rw_src;
    assign ForwardAE   = fwd_sel(rs1E, ctrl_m.reg_write, rdM, ctrl_w.reg_write, rdW);
    assign ForwardBE   = fwd_sel(rs2E, ctrl_m.reg_write, rdM, ctrl_w.reg_write, rdW);

    assign unused_w = ^{ctrl_w.mem_write, ctrl_w.alu_src, ctrl_w.alu_op,
                        ctrl_w.branch, ctrl_w.jump, ctrl_w.jalr, ctrl_w.funct3};

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e <= NOP_BUNDLE;
            ctrl_m <= NOP_BUNDLE;
            ctrl_w <= NOP_BUNDLE;
            rdE    <= '0;
            rdM    <= '0;
            rdW    <= '0;
            rs1E   <= '0;
            rs2E   <= '0;
        end else begin
            if (flush_e) begin
                ctrl_e <= NOP_BUNDLE;
                rdE    <= '0;
                rs1E   <= '0;
                rs2E   <= '0;
            end else begin
                ctrl_e <= ctrl_d;
                rdE    <= rdD;
                rs1E   <= rs1D;
                rs2E   <= rs2D;
            end
            ctrl_m <= ctrl_e;
            rdM    <= rdE;
            ctrl_w <= ctrl_m;
            rdW    <= rdM;
        end
    end

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: one forwarding and one stall-only instance
// driven in lockstep and compared with an instruction-level reference model.
module tb_control_pipeline;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   ZeroE, LtE, LtuE;
    instr_t cur;

    // Index 0: FORWARD_EN = 1, index 1: FORWARD_EN = 0.
    logic       StallF [2], StallD [2], FlushD [2], ALUSrcE [2], MemWriteM [2];
    logic       RegWriteW [2], ResultSrcW [2], RWSrcW [2];
    logic [1:0] PCSrcE [2], ForwardAE [2], ForwardBE [2];
    logic [3:0] ALUControlE [2];
    logic [2:0] ImmSrcD [2], MemSrcM [2];
    logic [4:0] rdE [2], rdM [2], rdW [2];

    int checks = 0;
    int errors = 0;

    instr_t pipe [2][3];   // [instance][E, M, W]; all-zero = bubble
    bit     flush_e [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_pipeline #(.ALUCTRL_W(4), .REG_W(5), .FORWARD_EN(g == 0)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .op(cur.op), .funct3(cur.f3), .funct7(cur.f7),
            .rs1D(cur.rs1), .rs2D(cur.rs2), .rdD(cur.rd),
            .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
            .StallF(StallF[g]), .StallD(StallD[g]), .FlushD(FlushD[g]),
            .PCSrcE(PCSrcE[g]), .ALUControlE(ALUControlE[g]), .ALUSrcE(ALUSrcE[g]),
            .ImmSrcD(ImmSrcD[g]), .ForwardAE(ForwardAE[g]), .ForwardBE(ForwardBE[g]),
            .MemWriteM(MemWriteM[g]), .MemSrcM(MemSrcM[g]),
            .RegWriteW(RegWriteW[g]), .ResultSrcW(ResultSrcW[g]), .RWSrcW(RWSrcW[g]),
            .rdE(rdE[g]), .rdM(rdM[g]), .rdW(rdW[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_known(input logic [6:0] o);
        return o inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic bit writes_rd(input logic [6:0] o);
        return o inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic bit uses_imm(input logic [6:0] o);
        return o inside {OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic logic [3:0] exp_alu(input instr_t i);
        alu_op_t by_f3 [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        alu_op_t a = by_f3[i.f3];
        if (i.f7[5] && i.f3 == 3'd5) a = ALU_SRA;
        if (i.f7[5] && i.f3 == 3'd0 && i.op == OP_R) a = ALU_SUB;
        case (i.op)
            OP_R, OP_I: return a;
            OP_LUI:     return ALU_PASSB;
            OP_BRANCH:  return ALU_SUB;
            default:    return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] exp_imm(input instr_t i);
        case (i.op)
            OP_STORE:         return 3'd1;
            OP_BRANCH:        return 3'd2;
            OP_JAL:           return 3'd3;
            OP_LUI, OP_AUIPC: return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_pc(input instr_t i, input bit z, input bit lt, input bit ltu);
        bit cond [8];
        cond = '{z, !z, 1'b0, 1'b0, lt, !lt, ltu, !ltu};
        if (i.op == OP_JALR) return 2'b11;
        if (i.op == OP_JAL) return 2'b01;
        if (i.op == OP_BRANCH && cond[i.f3]) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input instr_t m, input instr_t w);
        if (rs == 5'd0) return 2'b00;
        if (writes_rd(m.op) && m.rd == rs) return 2'b10;
        if (writes_rd(w.op) && w.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit reads(input instr_t producer, input instr_t d);
        return producer.rd != 5'd0 && (producer.rd == d.rs1 || producer.rd == d.rs2);
    endfunction

    task automatic model_check(input int d);
        instr_t e = pipe[d][0];
        instr_t m = pipe[d][1];
        instr_t w = pipe[d][2];
        logic [1:0] pc = exp_pc(e, ZeroE, LtE, LtuE);
        bit redir = (pc != 2'b00);
        bit hz, stall;
        logic [1:0] fa, fb;
        if (d == 0) hz = (e.op == OP_LOAD) && reads(e, cur);
        else        hz = (writes_rd(e.op) && reads(e, cur)) || (writes_rd(m.op) && reads(m, cur));
        stall = hz && !redir;
        fa = (d == 0) ? exp_fwd(e.rs1, m, w) : 2'b00;
        fb = (d == 0) ? exp_fwd(e.rs2, m, w) : 2'b00;
        check($sformatf("ctl%0d", d),
              {StallF[d], StallD[d], FlushD[d], PCSrcE[d], ForwardAE[d], ForwardBE[d]},
              {stall, stall, redir, pc, fa, fb});
        check($sformatf("ex%0d", d), {ALUControlE[d], ALUSrcE[d], rdE[d]},
              {exp_alu(e), uses_imm(e.op), e.rd});
        check($sformatf("mw%0d", d),
              {MemWriteM[d], MemSrcM[d], rdM[d], RegWriteW[d], ResultSrcW[d], RWSrcW[d], rdW[d]},
              {m.op == OP_STORE, is_known(m.op) ? m.f3 : 3'b000, m.rd,
               writes_rd(w.op), w.op == OP_LOAD, w.op inside {OP_JAL, OP_JALR}, w.rd});
        check($sformatf("imm%0d", d), ImmSrcD[d], exp_imm(cur));
        flush_e[d] = redir || stall;
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 3; s++) pipe[d][s] = '0;
    endtask

    // Check at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_check(d);
        @(posedge clk);
        if (!rst_n) model_clear();
        else begin
            for (int d = 0; d < 2; d++) begin
                pipe[d][2] = pipe[d][1];
                pipe[d][1] = pipe[d][0];
                pipe[d][0] = flush_e[d] ? instr_t'('0) : cur;
            end
        end
        #1;
    endtask

    task automatic drive(input instr_t i);
        cur = i;
        #1;
    endtask

    function automatic instr_t mk(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t i;
        i.op = o; i.f3 = f3; i.f7 = f7; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        logic [6:0] ops [10] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7f};
        instr_t i;
        i.op  = ops[$urandom_range(0, 9)];
        i.f3  = 3'($urandom);
        i.f7  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        i.rd  = 5'($urandom_range(0, 7));
        i.rs1 = 5'($urandom_range(0, 7));
        i.rs2 = 5'($urandom_range(0, 7));
        return i;
    endfunction

    instr_t nop, addi, lw5, add6, lw0, add_x0;
    int     stalls0, stalls1;

    initial begin
        nop    = '0;
        addi   = mk(OP_I, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0);
        lw5    = mk(OP_LOAD, 3'd2, 7'h00, 5'd5, 5'd2, 5'd0);
        add6   = mk(OP_R, 3'd0, 7'h00, 5'd6, 5'd5, 5'd1);
        lw0    = mk(OP_LOAD, 3'd2, 7'h00, 5'd0, 5'd2, 5'd0);
        add_x0 = mk(OP_R, 3'd0, 7'h00, 5'd9, 5'd0, 5'd0);
        rst_n = 1'b0; ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0; cur = '0;
        model_clear();

        // Reset with random decode inputs: everything registered or hazard-related is 0.
        repeat (3) begin
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            drive(rand_instr());
            for (int d = 0; d < 2; d++)
                check("rst_zero", {StallF[d], StallD[d], FlushD[d], PCSrcE[d], ForwardAE[d], ForwardBE[d],
                                   ALUControlE[d], ALUSrcE[d], MemWriteM[d], MemSrcM[d], RegWriteW[d],
                                   ResultSrcW[d], RWSrcW[d], rdE[d], rdM[d], rdW[d]}, 32'd0);
            cycle();
        end
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        rst_n = 1'b1;
        drive(addi); cycle();
        drive(nop);
        check("addi_src", ALUSrcE[0], 1);
        check("addi_alu", ALUControlE[0], ALU_ADD);
        cycle();

        // Load-use: one stall, one bubble, ADD forwarded from W.
        drive(lw5); cycle();
        drive(add6); check("lu_stall", StallF[0], 1); cycle();
        drive(add6); check("lu_release", StallD[0], 0); check("lu_bubble", rdE[0], 0); cycle();
        drive(nop);  check("lu_fwd", {ForwardAE[0], rdE[0]}, {2'b01, 5'd6}); cycle();
        repeat (3) begin drive(nop); cycle(); end

        // Back-to-back ALU: forwarding from M vs two stalls in stall-only mode.
        stalls0 = 0; stalls1 = 0;
        drive(mk(OP_R, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2)); cycle();
        for (int k = 0; k < 3; k++) begin
            drive(mk(OP_R, 3'd0, 7'h20, 5'd4, 5'd3, 5'd3));
            if (k == 1) begin
                check("b2b_fwd", {ForwardAE[0], ForwardBE[0]}, 4'b1010);
                check("b2b_sub", ALUControlE[0], ALU_SUB);
            end
            stalls0 += int'(StallD[0]); stalls1 += int'(StallD[1]);
            cycle();
        end
        check("b2b_stall_fwd", stalls0, 0);
        check("b2b_stall_only", stalls1, 2);
        repeat (3) begin drive(nop); cycle(); end

        // BLT taken flushes; BGEU with Ltu set falls through.
        drive(mk(OP_BRANCH, 3'd4, 7'h00, 5'd0, 5'd1, 5'd2)); cycle();
        LtE = 1'b1; drive(addi);
        check("blt_pc", {PCSrcE[0], FlushD[0]}, 3'b011);
        cycle();
        LtE = 1'b0; drive(nop);
        check("blt_bubble", {ALUControlE[0], ALUSrcE[0], rdE[0]}, 0);
        cycle();
        drive(mk(OP_BRANCH, 3'd7, 7'h00, 5'd0, 5'd1, 5'd2)); cycle();
        LtuE = 1'b1; drive(nop); check("bgeu_pc", PCSrcE[0], 2'b00); cycle();
        LtuE = 1'b0;
        repeat (2) begin drive(nop); cycle(); end

        // JALR in E while D depends on pending writers: the redirect wins.
        drive(mk(OP_LOAD, 3'd2, 7'h00, 5'd7, 5'd2, 5'd0)); cycle();
        drive(mk(OP_JALR, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0)); cycle();
        drive(mk(OP_R, 3'd0, 7'h00, 5'd8, 5'd1, 5'd7));
        for (int d = 0; d < 2; d++)
            check("jalr_redirect", {PCSrcE[d], FlushD[d], StallF[d]}, 4'b1110);
        cycle();
        drive(nop); cycle();
        drive(nop); check("jalr_wb", {RWSrcW[0], RegWriteW[0], rdW[0]}, {2'b11, 5'd1}); cycle();
        repeat (2) begin drive(nop); cycle(); end

        // x0 never stalls or forwards.
        drive(lw0); cycle();
        drive(add_x0); check("x0_stall", {StallF[0], StallF[1]}, 0); cycle();
        drive(nop); check("x0_fwd", {ForwardAE[0], ForwardBE[0]}, 0); cycle();
        repeat (3) begin drive(nop); cycle(); end

        // Reset in the middle of a stall, then in the middle of a flush.
        drive(lw5); cycle();
        drive(add6); check("pre_rst_stall", StallF[0], 1);
        rst_n = 1'b0; model_clear(); #1;
        check("rst_abort_stall", {StallF[0], StallD[0]}, 0);
        cycle();
        rst_n = 1'b1;
        drive(mk(OP_BRANCH, 3'd0, 7'h00, 5'd0, 5'd1, 5'd1)); cycle();
        ZeroE = 1'b1; drive(nop); check("pre_rst_flush", FlushD[0], 1);
        rst_n = 1'b0; model_clear(); #1;
        check("rst_abort_flush", {FlushD[0], PCSrcE[0]}, 0);
        cycle();
        rst_n = 1'b1; ZeroE = 1'b0;
        drive(addi); cycle();
        drive(nop); check("post_rst_decode", {ALUSrcE[0], ALUControlE[0]}, {1'b1, 4'(ALU_ADD)}); cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ZeroE = 1'($urandom); LtE = 1'($urandom); LtuE = 1'($urandom);
            drive(rand_instr());
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
